pipe_controller: RTL and testbench

- Parametrised five-stage pipelined MIPS controller.
- Decodes opcode/funct in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches and jr in EX; detects load-use and multiply-busy hazards.
- Drives stall/flush to the datapath and the per-stage regwrite signals used by the forwarding unit.

---
 rtl/pipe_controller_pkg.sv | 68 ++++++
 rtl/pipe_controller_if.sv | 53 +++++
 rtl/ctl_decode.sv | 66 ++++++
 rtl/pipe_controller.sv | 96 +++++++++
 tb/tb_pipe_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_controller_pkg.sv
// Shared MIPS control declarations: opcode/funct encodings, ALU op codes and
// the control bundle carried down the pipeline.
package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_MFHI = 6'h10,
    FN_MFLO = 6'h12,
    FN_MULT = 6'h18,
    FN_ADD  = 6'h20,
    FN_SUB  = 6'h22,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A
  } funct_t;

  localparam int ALUOP_W = 4;

  // Low three bits match the classic 3-bit ALU; bit 3 marks extended ops.
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'b1001;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic               regwrite;
    logic [1:0]         regdst;
    logic               alusrc;
    logic               branch;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
    logic               jumpr;
    logic               jal;
    logic [ALUOP_W-1:0] alucontrol;
    logic               is_mult;
    logic               is_mfx;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t ctrl_rtype(input logic [ALUOP_W-1:0] op);
    ctrl_t c;
    c            = CTRL_BUBBLE;
    c.regwrite   = 1'b1;
    c.regdst     = 2'b01;
    c.alucontrol = op;
    return c;
  endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// Controller <-> datapath bundle. Every field is a level signal sampled each
// cycle; there is no valid/ready handshake on this boundary.
interface pipe_ctl_if
  import mips_decls_p::*;
#(
  parameter int ALUCTL_W  = 3,
  parameter int REGADDR_W = 5
);
  opcode_t               opcode_d;
  funct_t                funct_d;
  logic [REGADDR_W-1:0]  rs_d;
  logic [REGADDR_W-1:0]  rt_d;
  logic [REGADDR_W-1:0]  writereg_e;
  logic                  zero_e;

  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  jump_d;
  logic                  pcsrc_e;
  logic                  jumpr_e;
  logic [1:0]            regdst_e;
  logic                  alusrc_e;
  logic                  jal_e;
  logic [ALUCTL_W-1:0]   alucontrol_e;
  logic                  muldiv_start_e;
  logic                  memwrite_m;
  logic                  memtoreg_e;
  logic                  memtoreg_m;
  logic                  memtoreg_w;
  logic                  regwrite_e;
  logic                  regwrite_m;
  logic                  regwrite_w;
  logic [3:0]            busy_cnt;

  // Datapath side.
  modport master (
    output opcode_d, funct_d, rs_d, rt_d, writereg_e, zero_e,
    input  stall_f, stall_d, flush_d, jump_d, pcsrc_e, jumpr_e, regdst_e,
           alusrc_e, jal_e, alucontrol_e, muldiv_start_e, memwrite_m,
           memtoreg_e, memtoreg_m, memtoreg_w, regwrite_e, regwrite_m,
           regwrite_w, busy_cnt
  );

  // Controller side.
  modport slave (
    input  opcode_d, funct_d, rs_d, rt_d, writereg_e, zero_e,
    output stall_f, stall_d, flush_d, jump_d, pcsrc_e, jumpr_e, regdst_e,
           alusrc_e, jal_e, alucontrol_e, muldiv_start_e, memwrite_m,
           memtoreg_e, memtoreg_m, memtoreg_w, regwrite_e, regwrite_m,
           regwrite_w, busy_cnt
  );
endinterface

// File: rtl/ctl_decode.sv
// Combinational ID-stage decode: opcode/funct to the control bundle.
// Anything not recognised decodes to the bubble.
module ctl_decode
  import mips_decls_p::*;
#(
  parameter bit EXT_ALU = 1'b0
) (
  input  opcode_t opcode_i,
  input  funct_t  funct_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  ctrl_o = ctrl_rtype(ALU_ADD);
          FN_SUB:  ctrl_o = ctrl_rtype(ALU_SUB);
          FN_AND:  ctrl_o = ctrl_rtype(ALU_AND);
          FN_OR:   ctrl_o = ctrl_rtype(ALU_OR);
          FN_SLT:  ctrl_o = ctrl_rtype(ALU_SLT);
          FN_NOR:  if (EXT_ALU) ctrl_o = ctrl_rtype(ALU_NOR);
          FN_SLL:  if (EXT_ALU) ctrl_o = ctrl_rtype(ALU_SLL);
          FN_SRL:  if (EXT_ALU) ctrl_o = ctrl_rtype(ALU_SRL);
          FN_JR:   ctrl_o.jumpr = 1'b1;
          FN_MULT: ctrl_o.is_mult = 1'b1;
          FN_MFHI, FN_MFLO: begin
            ctrl_o        = ctrl_rtype(ALU_AND);
            ctrl_o.is_mfx = 1'b1;
          end
          default: ctrl_o = CTRL_BUBBLE;
        endcase
      end
      OP_LW: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.alucontrol = ALU_ADD;
      end
      OP_J:    ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.jal      = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 2'b10;
      end
      default: ctrl_o = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Five-stage MIPS pipeline controller: decode, ID/EX/MEM/WB control registers,
// redirect resolution, load-use and multiply-busy hazards.
module pipe_controller
  import mips_decls_p::*;
#(
  parameter int ALUCTL_W   = 3,
  parameter int MULDIV_LAT = 4,
  parameter int REGADDR_W  = 5
) (
  input logic      clk,
  input logic      reset,
  pipe_ctl_if.slave bus
);

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  ctrl_t     ctrl_d;
  ctrl_t     ctrl_e_d, ctrl_e_q;
  mem_ctrl_t ctrl_m_d, ctrl_m_q;
  wb_ctrl_t  ctrl_w_d, ctrl_w_q;
  logic [3:0] busy_d, busy_q, busy_dec;
  logic redir_e, lwstall, mdstall, hazard, jump_go;
  logic unused_e;

  ctl_decode #(.EXT_ALU(ALUCTL_W >= 4)) u_decode (
    .opcode_i (bus.opcode_d),
    .funct_i  (bus.funct_d),
    .ctrl_o   (ctrl_d)
  );

  // Hazards compare against the post-decrement count so mfhi/mflo/mult can
  // leave ID in the same cycle the counter reaches zero.
  always_comb begin
    busy_dec = (busy_q != 4'd0) ? busy_q - 4'd1 : 4'd0;
    redir_e  = (ctrl_e_q.branch & bus.zero_e) | ctrl_e_q.jumpr;
    lwstall  = ctrl_e_q.memtoreg & (bus.writereg_e != '0) &
               ((bus.rs_d == bus.writereg_e) | (bus.rt_d == bus.writereg_e));
    mdstall  = (busy_dec != 4'd0) & (ctrl_d.is_mult | ctrl_d.is_mfx);
    hazard   = ~redir_e & (lwstall | mdstall);
    jump_go  = ctrl_d.jump & ~redir_e & ~hazard;
    ctrl_e_d = (redir_e | hazard) ? CTRL_BUBBLE : ctrl_d;
    busy_d   = ctrl_e_d.is_mult ? 4'(MULDIV_LAT) : busy_dec;
    ctrl_m_d = '{regwrite: ctrl_e_q.regwrite,
                 memtoreg: ctrl_e_q.memtoreg,
                 memwrite: ctrl_e_q.memwrite};
    ctrl_w_d = '{regwrite: ctrl_m_q.regwrite,
                 memtoreg: ctrl_m_q.memtoreg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q <= CTRL_BUBBLE;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
      busy_q   <= 4'd0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.stall_f        = hazard;
  assign bus.stall_d        = hazard;
  assign bus.flush_d        = redir_e | jump_go;
  assign bus.jump_d         = jump_go;
  assign bus.pcsrc_e        = ctrl_e_q.branch & bus.zero_e;
  assign bus.jumpr_e        = ctrl_e_q.jumpr;
  assign bus.regdst_e       = ctrl_e_q.regdst;
  assign bus.alusrc_e       = ctrl_e_q.alusrc;
  assign bus.jal_e          = ctrl_e_q.jal;
  assign bus.alucontrol_e   = ALUCTL_W'(ctrl_e_q.alucontrol);
  assign bus.muldiv_start_e = ctrl_e_q.is_mult;
  assign bus.memtoreg_e     = ctrl_e_q.memtoreg;
  assign bus.regwrite_e     = ctrl_e_q.regwrite;
  assign bus.memwrite_m     = ctrl_m_q.memwrite;
  assign bus.memtoreg_m     = ctrl_m_q.memtoreg;
  assign bus.regwrite_m     = ctrl_m_q.regwrite;
  assign bus.memtoreg_w     = ctrl_w_q.memtoreg;
  assign bus.regwrite_w     = ctrl_w_q.regwrite;
  assign bus.busy_cnt       = busy_q;

  // jump and is_mfx have done their work by the time the bundle is in EX.
  assign unused_e = ^{ctrl_e_q.jump, ctrl_e_q.is_mfx};

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: two instances (ALUCTL_W=3 and 4) share
// the same ID-stage stimulus.
module tb_pipe_controller;
  import mips_decls_p::*;

  localparam opcode_t OP_NONE = opcode_t'(6'h3F);

  logic clk = 1'b0;
  logic reset = 1'b1;
  opcode_t op;
  funct_t  fn;
  logic [4:0] rs, rt, wreg;
  logic zero;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  pipe_ctl_if #(.ALUCTL_W(3), .REGADDR_W(5)) bus3 ();
  pipe_ctl_if #(.ALUCTL_W(4), .REGADDR_W(5)) bus4 ();

  assign bus3.opcode_d = op;   assign bus4.opcode_d = op;
  assign bus3.funct_d = fn;    assign bus4.funct_d = fn;
  assign bus3.rs_d = rs;       assign bus4.rs_d = rs;
  assign bus3.rt_d = rt;       assign bus4.rt_d = rt;
  assign bus3.writereg_e = wreg; assign bus4.writereg_e = wreg;
  assign bus3.zero_e = zero;   assign bus4.zero_e = zero;

  pipe_controller #(.ALUCTL_W(3), .MULDIV_LAT(4), .REGADDR_W(5)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3));
  pipe_controller #(.ALUCTL_W(4), .MULDIV_LAT(4), .REGADDR_W(5)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input opcode_t o, input funct_t f, input logic [4:0] s, input logic [4:0] t);
    op = o; fn = f; rs = s; rt = t;
    #1;
  endtask

  task automatic idle();
    drive(OP_NONE, FN_ADD, 5'd0, 5'd0);
  endtask

  task automatic drain();
    wreg = 5'd0; zero = 1'b0;
    repeat (5) begin
      tick();
      idle();
    end
  endtask

  logic [3:0] rw_tab = 4'b1001;
  logic [3:0] mw_tab = 4'b0010;

  initial begin
    op = OP_NONE; fn = FN_ADD; rs = '0; rt = '0; wreg = '0; zero = 1'b0;
    #2;
    check("rst_regwrite_e", bus3.regwrite_e, 0);
    check("rst_busy", bus3.busy_cnt, 0);
    tick();
    check("rst_memwrite_m", bus3.memwrite_m, 0);
    reset = 1'b0;
    tick();
    idle();
    check("post_rst_regwrite_w", bus3.regwrite_w, 0);
    check("post_rst_muldiv", bus3.muldiv_start_e, 0);

    // load-use: lw $8 ; add $9,$8,$10
    tick(); drive(OP_LW, FN_ADD, 5'd0, 5'd8);
    check("lu_nostall0", bus3.stall_d, 0);
    tick(); wreg = 5'd8; drive(OP_RTYPE, FN_ADD, 5'd8, 5'd10);
    check("lu_memtoreg_e", bus3.memtoreg_e, 1);
    check("lu_stall_f", bus3.stall_f, 1);
    check("lu_stall_d", bus3.stall_d, 1);
    check("lu_flush_d", bus3.flush_d, 0);
    tick(); wreg = 5'd0; #1;
    check("lu_stall_clear", bus3.stall_d, 0);
    check("lu_bubble_regwrite_e", bus3.regwrite_e, 0);
    check("lu_memtoreg_m", bus3.memtoreg_m, 1);
    tick(); idle();
    check("lu_add_regwrite_e", bus3.regwrite_e, 1);
    check("lu_add_regdst_e", bus3.regdst_e, 2'b01);
    check("lu_add_alu", bus3.alucontrol_e, 32'(ALU_ADD));
    check("lu_memtoreg_w", bus3.memtoreg_w, 1);
    check("lu_regwrite_w", bus3.regwrite_w, 1);
    drain();

    // mult ; mflo with MULDIV_LAT=4
    tick(); drive(OP_RTYPE, FN_MULT, 5'd1, 5'd2);
    check("md_nostall_mult", bus3.stall_d, 0);
    tick(); drive(OP_RTYPE, FN_MFLO, 5'd0, 5'd0);
    check("md_start", bus3.muldiv_start_e, 1);
    check("md_busy4", bus3.busy_cnt, 4);
    check("md_stall1", bus3.stall_d, 1);
    tick(); #1;
    check("md_start_once", bus3.muldiv_start_e, 0);
    check("md_stall2", bus3.stall_f, 1);
    check("md_bubble", bus3.regwrite_e, 0);
    tick(); #1;
    check("md_stall3", bus3.stall_d, 1);
    tick(); #1;
    check("md_busy1", bus3.busy_cnt, 1);
    check("md_release", bus3.stall_d, 0);
    tick(); idle();
    check("md_mflo_ex", bus3.regwrite_e, 1);
    check("md_busy0", bus3.busy_cnt, 0);
    drain();

    // beq taken in EX beats an mflo stall pending in ID
    tick(); drive(OP_RTYPE, FN_MULT, 5'd1, 5'd2);
    tick(); drive(OP_BEQ, FN_ADD, 5'd1, 5'd2);
    check("br_nostall", bus3.stall_d, 0);
    tick(); zero = 1'b1; drive(OP_RTYPE, FN_MFLO, 5'd0, 5'd0);
    check("br_pcsrc", bus3.pcsrc_e, 1);
    check("br_flush", bus3.flush_d, 1);
    check("br_stall_d", bus3.stall_d, 0);
    check("br_stall_f", bus3.stall_f, 0);
    tick(); zero = 1'b0; drive(OP_RTYPE, FN_ADD, 5'd3, 5'd4);
    check("br_after_pcsrc", bus3.pcsrc_e, 0);
    check("br_after_stall", bus3.stall_d, 0);
    check("br_after_flush", bus3.flush_d, 0);
    check("br_squashed", bus3.regwrite_e, 0);
    drain();

    // j held behind a load-use stall
    tick(); drive(OP_LW, FN_ADD, 5'd0, 5'd9);
    tick(); wreg = 5'd9; drive(OP_J, FN_ADD, 5'd9, 5'd0);
    check("j_stall", bus3.stall_d, 1);
    check("j_held", bus3.jump_d, 0);
    check("j_noflush", bus3.flush_d, 0);
    tick(); wreg = 5'd0; #1;
    check("j_go", bus3.jump_d, 1);
    check("j_flush", bus3.flush_d, 1);
    tick(); idle();
    check("j_once", bus3.jump_d, 0);
    check("j_flush_once", bus3.flush_d, 0);
    drain();

    // jr redirect from EX
    tick(); drive(OP_RTYPE, FN_JR, 5'd31, 5'd0);
    check("jr_noflush_id", bus3.flush_d, 0);
    tick(); drive(OP_RTYPE, FN_ADD, 5'd1, 5'd2);
    check("jr_jumpr_e", bus3.jumpr_e, 1);
    check("jr_flush", bus3.flush_d, 1);
    tick(); idle();
    check("jr_jumpr_clear", bus3.jumpr_e, 0);
    check("jr_squash", bus3.regwrite_e, 0);
    drain();

    // jal: regdst r31
    tick(); drive(OP_JAL, FN_ADD, 5'd0, 5'd0);
    check("jal_jump_d", bus3.jump_d, 1);
    tick(); idle();
    check("jal_regdst", bus3.regdst_e, 2'b10);
    check("jal_jal_e", bus3.jal_e, 1);
    check("jal_regwrite", bus3.regwrite_e, 1);
    drain();

    // nor with narrow and wide ALU control
    tick(); drive(OP_RTYPE, FN_NOR, 5'd1, 5'd2);
    tick(); idle();
    check("nor4_alu", bus4.alucontrol_e, 32'(ALU_NOR));
    check("nor4_regwrite", bus4.regwrite_e, 1);
    check("nor3_bubble", bus3.regwrite_e, 0);
    check("nor3_alu", bus3.alucontrol_e, 0);
    drain();

    // addi, sw, none, addi: memwrite_m at +2, regwrite_w at +3
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0 || i == 3) drive(OP_ADDI, FN_ADD, 5'd1, 5'd5);
      else if (i == 1) drive(OP_SW, FN_ADD, 5'd2, 5'd5);
      else idle();
      exp_q.push_back((i < 4) ? rw_tab[i] : 1'b0);
      if (i >= 2) check("lat_memwrite_m", bus3.memwrite_m, (i - 2 < 4) ? 32'(mw_tab[i-2]) : 0);
      if (exp_q.size() > 3) check("lat_regwrite_w", bus3.regwrite_w, 32'(exp_q.pop_front()));
    end
    drain();

    // asynchronous reset with sw in MEM and multiplier busy
    tick(); drive(OP_RTYPE, FN_MULT, 5'd1, 5'd2);
    tick(); drive(OP_SW, FN_ADD, 5'd2, 5'd5);
    tick(); idle();
    tick(); #1;
    check("ar_memwrite_pre", bus3.memwrite_m, 1);
    check("ar_busy_pre", bus3.busy_cnt, 2);
    reset = 1'b1;
    #1;
    check("ar_memwrite_m", bus3.memwrite_m, 0);
    check("ar_busy", bus3.busy_cnt, 0);
    check("ar_regwrite_m", bus3.regwrite_m, 0);
    check("ar_regwrite_w", bus3.regwrite_w, 0);
    tick();
    reset = 1'b0;
    tick(); #1;
    check("ar_after_regwrite_e", bus3.regwrite_e, 0);
    check("ar_after_muldiv", bus3.muldiv_start_e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
